// File: rtl/hilo_fwd_pipe.sv
// HI/LO register owner with a STAGES-deep in-flight producer pipeline.
// Forwards the youngest pending HI/LO value, back-fills late results and commits the tail.
module hilo_fwd_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 3,
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              flush,
  input  logic              issue_w_en_hi,
  input  logic              issue_w_en_lo,
  input  logic [DATA_W-1:0] issue_data_hi,
  input  logic [DATA_W-1:0] issue_data_lo,
  input  logic              issue_hi_valid,
  input  logic              issue_lo_valid,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [DATA_W-1:0] fill_hi,
  input  logic [DATA_W-1:0] fill_lo,
  input  logic              r_en_hi,
  input  logic              r_en_lo,
  output logic [DATA_W-1:0] ope_data_hi,
  output logic [DATA_W-1:0] ope_data_lo,
  output logic              hi_data_valid,
  output logic              lo_data_valid,
  output logic              stall_req,
  output logic              tail_pending,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  logic [STAGES-1:0] occ_q, occ_d;
  logic [STAGES-1:0] weh_q, weh_d, wel_q, wel_d;
  logic [STAGES-1:0] vh_q, vh_d, vl_q, vl_d;
  logic [DATA_W-1:0] dh_q [STAGES];
  logic [DATA_W-1:0] dh_d [STAGES];
  logic [DATA_W-1:0] dl_q [STAGES];
  logic [DATA_W-1:0] dl_d [STAGES];
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              shift;
  logic              fill_hit;
  int                fidx;
  int                fill_tgt;

  // The tail blocks the pipe while any half it will commit is still unresolved.
  assign tail_pending = occ_q[STAGES-1] &
                        ((weh_q[STAGES-1] & ~vh_q[STAGES-1]) |
                         (wel_q[STAGES-1] & ~vl_q[STAGES-1]));
  assign shift = advance & ~tail_pending & ~flush;

  always_comb begin
    occ_d    = occ_q;
    weh_d    = weh_q;
    wel_d    = wel_q;
    vh_d     = vh_q;
    vl_d     = vl_q;
    dh_d     = dh_q;
    dl_d     = dl_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    fill_hit = 1'b0;
    fidx     = int'(fill_idx);
    fill_tgt = fidx + (shift ? 1 : 0);
    for (int i = 0; i < STAGES; i++) begin
      if (fill_en && (i == fidx) && occ_q[i]) fill_hit = 1'b1;
    end
    if (flush) begin
      occ_d = '0;
    end else begin
      if (shift) begin
        for (int i = STAGES - 1; i > 0; i--) begin
          occ_d[i] = occ_q[i-1];
          weh_d[i] = weh_q[i-1];
          wel_d[i] = wel_q[i-1];
          vh_d[i]  = vh_q[i-1];
          vl_d[i]  = vl_q[i-1];
          dh_d[i]  = dh_q[i-1];
          dl_d[i]  = dl_q[i-1];
        end
        occ_d[0] = issue_w_en_hi | issue_w_en_lo;
        weh_d[0] = issue_w_en_hi;
        wel_d[0] = issue_w_en_lo;
        vh_d[0]  = issue_hi_valid;
        vl_d[0]  = issue_lo_valid;
        dh_d[0]  = issue_data_hi;
        dl_d[0]  = issue_data_lo;
        if (occ_q[STAGES-1]) begin
          if (weh_q[STAGES-1]) hi_d = dh_q[STAGES-1];
          if (wel_q[STAGES-1]) lo_d = dl_q[STAGES-1];
        end
      end
      // A fill follows its entry to where it lands after this cycle's shift.
      if (fill_hit) begin
        for (int i = 0; i < STAGES; i++) begin
          if (i == fill_tgt) begin
            if (weh_d[i]) begin
              dh_d[i] = fill_hi;
              vh_d[i] = 1'b1;
            end
            if (wel_d[i]) begin
              dl_d[i] = fill_lo;
              vl_d[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      occ_q <= occ_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Payload fields are qualified by occ_q, so they need no reset.
  always_ff @(posedge clk) begin
    weh_q <= weh_d;
    wel_q <= wel_d;
    vh_q  <= vh_d;
    vl_q  <= vl_d;
    dh_q  <= dh_d;
    dl_q  <= dl_d;
  end

  logic [DATA_W-1:0] src_hi, src_lo;
  logic              src_hv, src_lv;

  // Walk oldest to youngest so the youngest eligible producer wins.
  always_comb begin
    src_hi = hi_q;
    src_lo = lo_q;
    src_hv = 1'b1;
    src_lv = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (occ_q[i] && weh_q[i]) begin
        src_hi = dh_q[i];
        src_hv = vh_q[i];
      end
      if (occ_q[i] && wel_q[i]) begin
        src_lo = dl_q[i];
        src_lv = vl_q[i];
      end
    end
    if (issue_w_en_hi) begin
      src_hi = issue_data_hi;
      src_hv = issue_hi_valid;
    end
    if (issue_w_en_lo) begin
      src_lo = issue_data_lo;
      src_lv = issue_lo_valid;
    end
  end

  assign ope_data_hi   = r_en_hi ? src_hi : '0;
  assign ope_data_lo   = r_en_lo ? src_lo : '0;
  assign hi_data_valid = ~r_en_hi | src_hv;
  assign lo_data_valid = ~r_en_lo | src_lv;
  assign stall_req     = (r_en_hi & ~hi_data_valid) | (r_en_lo & ~lo_data_valid);

endmodule

// File: tb/tb_hilo_fwd_pipe.sv
// Directed bench for hilo_fwd_pipe (STAGES=3): a per-cycle vector table plus a
// hand-written reset-during-stall sequence.
module tb_hilo_fwd_pipe;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          advance, flush;
  logic          issue_w_en_hi, issue_w_en_lo;
  logic [DW-1:0] issue_data_hi, issue_data_lo;
  logic          issue_hi_valid, issue_lo_valid;
  logic          fill_en;
  logic [1:0]    fill_idx;
  logic [DW-1:0] fill_hi, fill_lo;
  logic          r_en_hi, r_en_lo;
  logic [DW-1:0] ope_data_hi, ope_data_lo;
  logic          hi_data_valid, lo_data_valid, stall_req, tail_pending;
  logic [DW-1:0] hi_q, lo_q;

  int n_cmp = 0;
  int n_err = 0;

  hilo_fwd_pipe #(.DATA_W(DW), .STAGES(3)) dut (
    .clk(clk), .rst(rst), .advance(advance), .flush(flush),
    .issue_w_en_hi(issue_w_en_hi), .issue_w_en_lo(issue_w_en_lo),
    .issue_data_hi(issue_data_hi), .issue_data_lo(issue_data_lo),
    .issue_hi_valid(issue_hi_valid), .issue_lo_valid(issue_lo_valid),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_hi(fill_hi), .fill_lo(fill_lo),
    .r_en_hi(r_en_hi), .r_en_lo(r_en_lo),
    .ope_data_hi(ope_data_hi), .ope_data_lo(ope_data_lo),
    .hi_data_valid(hi_data_valid), .lo_data_valid(lo_data_valid),
    .stall_req(stall_req), .tail_pending(tail_pending),
    .hi_q(hi_q), .lo_q(lo_q)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    ctl;    // {advance, flush}
    logic [3:0]    iss;    // {w_en_hi, w_en_lo, hi_valid, lo_valid}
    logic [DW-1:0] idh, idl;
    logic [2:0]    fil;    // {fill_en, fill_idx}
    logic [DW-1:0] fh, fl;
    logic [1:0]    rd;     // {r_en_hi, r_en_lo}
    logic [DW-1:0] e_hi, e_lo;
    logic [3:0]    e_fl;   // {hi_valid, lo_valid, stall_req, tail_pending}
    logic [DW-1:0] e_hq, e_lq;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [1:0] ctl, logic [3:0] iss, logic [DW-1:0] idh,
                              logic [DW-1:0] idl, logic [2:0] fil, logic [DW-1:0] fh,
                              logic [DW-1:0] fl, logic [1:0] rd, logic [DW-1:0] e_hi,
                              logic [DW-1:0] e_lo, logic [3:0] e_fl,
                              logic [DW-1:0] e_hq, logic [DW-1:0] e_lq);
    vec_t v;
    v.ctl = ctl; v.iss = iss; v.idh = idh; v.idl = idl;
    v.fil = fil; v.fh = fh; v.fl = fl; v.rd = rd;
    v.e_hi = e_hi; v.e_lo = e_lo; v.e_fl = e_fl; v.e_hq = e_hq; v.e_lq = e_lq;
    return v;
  endfunction

  // driver tasks
  task automatic drive_idle();
    advance = 0; flush = 0;
    issue_w_en_hi = 0; issue_w_en_lo = 0; issue_data_hi = '0; issue_data_lo = '0;
    issue_hi_valid = 0; issue_lo_valid = 0;
    fill_en = 0; fill_idx = '0; fill_hi = '0; fill_lo = '0;
    r_en_hi = 0; r_en_lo = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    {advance, flush} = v.ctl;
    {issue_w_en_hi, issue_w_en_lo, issue_hi_valid, issue_lo_valid} = v.iss;
    issue_data_hi = v.idh; issue_data_lo = v.idl;
    {fill_en, fill_idx} = v.fil;
    fill_hi = v.fh; fill_lo = v.fl;
    {r_en_hi, r_en_lo} = v.rd;
  endtask

  // scoreboard
  task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [DW-1:0] e_hi, input logic [DW-1:0] e_lo,
                         input logic [3:0] e_fl, input logic [DW-1:0] e_hq,
                         input logic [DW-1:0] e_lq);
    chk("ope_data_hi", idx, ope_data_hi, e_hi);
    chk("ope_data_lo", idx, ope_data_lo, e_lo);
    chk("hi_data_valid", idx, DW'(hi_data_valid), DW'(e_fl[3]));
    chk("lo_data_valid", idx, DW'(lo_data_valid), DW'(e_fl[2]));
    chk("stall_req", idx, DW'(stall_req), DW'(e_fl[1]));
    chk("tail_pending", idx, DW'(tail_pending), DW'(e_fl[0]));
    chk("hi_q", idx, hi_q, e_hq);
    chk("lo_q", idx, lo_q, e_lq);
  endtask

  initial begin
    // reset state and idle reads
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 4'b1100, 0, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 0, 0, 4'b1100, 0, 0));
    // youngest wins, commit after three shifts
    tv.push_back(mk(2'b10, 4'b1010, 'h11, 0, 3'b000, 0, 0, 2'b10, 'h11, 0, 4'b1100, 0, 0));
    tv.push_back(mk(2'b10, 4'b1010, 'h22, 0, 3'b000, 0, 0, 2'b10, 'h22, 0, 4'b1100, 0, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h22, 0, 4'b1100, 0, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h22, 0, 4'b1100, 0, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h22, 0, 4'b1100, 'h11, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h22, 0, 4'b1100, 'h11, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h22, 0, 4'b1100, 'h22, 0));
    // pending producer, fill at stage 0
    tv.push_back(mk(2'b10, 4'b1000, 'h99, 0, 3'b000, 0, 0, 2'b00, 0, 0, 4'b1100, 'h22, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b100, 'hDEAD, 0, 2'b10, 'h99, 0, 4'b0110, 'h22, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'hDEAD, 0, 4'b1100, 'h22, 0));
    // pending producer reaches tail and blocks; fill tail, then commit
    tv.push_back(mk(2'b10, 4'b1000, 'h77, 0, 3'b000, 0, 0, 2'b10, 'h77, 0, 4'b0110, 'h22, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 4'b1100, 'h22, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h77, 0, 4'b0110, 'h22, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h77, 0, 4'b0111, 'hDEAD, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b110, 'h1234, 0, 2'b00, 0, 0, 4'b1101, 'hDEAD, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h1234, 0, 4'b1100, 'hDEAD, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 4'b1100, 'hDEAD, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b10, 'h1234, 0, 4'b1100, 'h1234, 0));
    // fill during a shift lands on the shifted copy
    tv.push_back(mk(2'b10, 4'b1100, 'hA0, 'hB0, 3'b000, 0, 0, 2'b11, 'hA0, 'hB0, 4'b0010, 'h1234, 0));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b100, 'hC1, 'hC2, 2'b11, 'hA0, 'hB0, 4'b0010, 'h1234, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 'hC1, 'hC2, 4'b1100, 'h1234, 0));
    // three in flight, then flush with advance and fill
    tv.push_back(mk(2'b10, 4'b1111, 'h31, 'h41, 3'b000, 0, 0, 2'b00, 0, 0, 4'b1100, 'h1234, 0));
    tv.push_back(mk(2'b10, 4'b1111, 'h32, 'h42, 3'b000, 0, 0, 2'b00, 0, 0, 4'b1100, 'h1234, 0));
    tv.push_back(mk(2'b10, 4'b1111, 'h33, 'h43, 3'b000, 0, 0, 2'b00, 0, 0, 4'b1100, 'hC1, 'hC2));
    tv.push_back(mk(2'b11, 4'b0000, 0, 0, 3'b100, 'hEE, 'hEE, 2'b11, 'h33, 'h43, 4'b1100, 'hC1, 'hC2));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 'hC1, 'hC2, 4'b1100, 'hC1, 'hC2));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 'hC1, 'hC2, 4'b1100, 'hC1, 'hC2));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 'hC1, 'hC2, 4'b1100, 'hC1, 'hC2));
    // LO-only then HI-only producers; disabled halves carry junk that must never commit
    tv.push_back(mk(2'b10, 4'b0101, 'hFFFF, 'h5A, 3'b000, 0, 0, 2'b11, 'hC1, 'h5A, 4'b1100, 'hC1, 'hC2));
    tv.push_back(mk(2'b10, 4'b1010, 'hA5, 'hEEEE, 3'b000, 0, 0, 2'b11, 'hA5, 'h5A, 4'b1100, 'hC1, 'hC2));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 'hA5, 'h5A, 4'b1100, 'hC1, 'hC2));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 'hA5, 'h5A, 4'b1100, 'hC1, 'hC2));
    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 'hA5, 'h5A, 4'b1100, 'hC1, 'h5A));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 3'b000, 0, 0, 2'b11, 'hA5, 'h5A, 4'b1100, 'hA5, 'h5A));

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < tv.size(); k++) begin
      drive_vec(tv[k]);
      #1;
      chk_all(k, tv[k].e_hi, tv[k].e_lo, tv[k].e_fl, tv[k].e_hq, tv[k].e_lq);
      @(negedge clk);
    end

    // reset while a pending producer stalls the tail
    drive_idle();
    advance = 1; issue_w_en_hi = 1; issue_data_hi = 'h66; issue_hi_valid = 0;
    @(negedge clk);
    drive_idle();
    advance = 1;
    repeat (2) @(negedge clk);
    r_en_hi = 1;
    #1;
    chk_all(100, 'h66, 0, 4'b0111, 'hA5, 'h5A);
    @(negedge clk);
    #1;
    chk_all(101, 'h66, 0, 4'b0111, 'hA5, 'h5A);
    @(negedge clk);
    rst = 1; fill_en = 1; fill_idx = 2'd2; fill_hi = 'h77;
    @(negedge clk);
    rst = 0; fill_en = 0;
    #1;
    chk_all(102, 0, 0, 4'b1100, 0, 0);
    @(negedge clk);
    #1;
    chk_all(103, 0, 0, 4'b1100, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_fwd_pipe.md
# hilo_fwd_pipe

Parametrised successor to the combinational HI/LO forwarding check. It owns the architectural HI/LO registers and a STAGES-deep shift pipeline of in-flight HI/LO producers. It forwards the youngest pending value to the reader and back-fills late multi-cycle (mul/div) results. It raises a stall when the selected source is not yet valid, and commits the tail entry to HI/LO. It sits beside the decode/issue stage of the MIPS core.

## Interface
- DATA_W, 32, width of HI, LO and all data ports.
- STAGES, 3, number of in-flight entries between issue and commit (≥1); IDX_W = max(1, clog2(STAGES)).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- advance  in  1  pipeline-move request from global control.
- flush  in  1  discard all in-flight entries.
- issue_w_en_hi, issue_w_en_lo  in  1 each  the producer entering stage 0 writes HI / LO.
- issue_data_hi, issue_data_lo  in  DATA_W each  producer data.
- issue_hi_valid, issue_lo_valid  in  1 each  data already final (0 = pending multi-cycle result).
- fill_en  in  1  late result arrives.
- fill_idx  in  IDX_W  stage index of the entry being filled (0 = youngest).
- fill_hi, fill_lo  in  DATA_W each  late result data.
- r_en_hi, r_en_lo  in  1 each  the reader needs HI / LO.
- ope_data_hi, ope_data_lo  out  DATA_W each  forwarded operand; 0 when the matching r_en is low.
- hi_data_valid, lo_data_valid  out  1 each  forwarded operand is final; 1 when the matching r_en is low.
- stall_req  out  1  = (r_en_hi & ~hi_data_valid) | (r_en_lo & ~lo_data_valid).
- tail_pending  out  1  tail entry is occupied and an enabled half is still invalid.
- hi_q, lo_q  out  DATA_W each  architectural HI / LO.

## Operation
- Entry fields: occ, w_en_hi, w_en_lo, data_hi, data_lo, v_hi, v_lo. Entry 0 is the youngest; entry STAGES-1 is the tail.
- shift = advance & ~tail_pending & ~flush.
- On shift:
  - entry[i+1] ← entry[i].
  - entry[0] ← issue fields, with occ = issue_w_en_hi | issue_w_en_lo.
  - If the tail is occupied, hi_q ← tail data_hi when w_en_hi; lo_q ← tail data_lo when w_en_lo.
- Without shift, entries hold and the issue port is ignored. Upstream must treat tail_pending as a stall.
- flush: all occ ← 0 next cycle and no commit that cycle. flush has priority over shift and fill.
- Fill:
  - Targets entry[fill_idx] as seen in the current cycle. If that entry is unoccupied, the fill is ignored.
  - For each enabled half, data ← fill value and valid ← 1. Disabled halves are untouched.
  - If a shift happens in the same cycle, the fill is applied to the shifted copy at fill_idx+1.
  - A fill at the tail in a shift cycle cannot occur, because tail_pending blocks the shift.
  - fill_idx ≥ STAGES is ignored.
- Forwarding, combinational. Priority for HI: issue port (issue_w_en_hi) > entry[0] > … > entry[STAGES-1] > hi_q. Only occupied entries with w_en_hi set are eligible. LO is identical using the lo fields.
  - The selected source supplies both data and valid. The architectural register is always valid.
  - A fill is not forwarded in its own cycle; it becomes visible the next cycle.
- Commit and fill of the same cycle: the tail cannot be both pending and shifted, so there is no conflict.

## Timing
- Reset, sampled on a clk edge with rst=1:
  - all occ = 0, hi_q = lo_q = 0.
  - Outputs then follow the combinational rules: with r_en low, ope_* = 0, *_data_valid = 1, stall_req = 0. tail_pending = 0.
  - rst overrides flush, fill and shift. Reset mid-fill or mid-stall discards all entries.
- Forward path: zero latency, combinational from issue, entries, hi_q, lo_q and r_en.
- Issue to commit: a producer issued in cycle t reaches the tail after STAGES-1 shifts. It commits on the next shift, i.e. hi_q updates STAGES shift-cycles after issue.
- Fill to forward valid: 1 cycle.
- tail_pending and stall_req are combinational; no registered outputs other than hi_q, lo_q and the entries.

## Test plan
- Reset then r_en_hi=1 with no producers -> ope_data_hi=0, hi_data_valid=1, stall_req=0. With r_en_hi=0 -> ope_data_hi=0.
- Issue HI=0x11 (valid); advance each cycle; issue HI=0x22 next cycle; read HI every cycle.
  - Required: the youngest value wins (0x22 once issued), and hi_q=0x11 after 3 shifts with STAGES=3.
- Issue w_en_hi=1 with hi_valid=0; r_en_hi=1 the next cycle.
  - Required: hi_data_valid=0 and stall_req=1.
  - fill_en at idx 0 with fill_hi=0xDEAD: the next cycle ope_data_hi=0xDEAD, valid=1, stall_req=0.
- Pending entry reaches the tail with advance=1.
  - Required: tail_pending=1, no shift and hi_q unchanged.
  - Fill the tail: commit occurs on the following advance.
- Three producers in flight, then flush=1 together with advance=1 and fill_en.
  - Required: no commit, all entries empty next cycle, and a read returns hi_q/lo_q.
- LO-only producer (0x5A) followed by HI-only producer (0xA5); read both.
  - Required: ope_data_lo=0x5A and ope_data_hi=0xA5, each independently sourced, and the disabled halves are never committed.
